fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction decoder.
- Owns the program counter and issues single-outstanding requests to instruction memory.
- Holds each returned 16-bit instruction in a one-entry output buffer until the decoder accepts it.
- Accepts PC redirects from the branch/jump resolution logic and squashes any stale in-flight fetch.

Parameters:
- PC_WIDTH, 16, width of PC and instruction memory address.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, PC increment per fetched instruction (word-addressed memory).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_WIDTH  fetch address, equals current pc.
- imem_ready  in  1  memory accepts request this cycle when imem_req=1.
- imem_rvalid  in  1  read data valid; exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rdata  in  16  returned instruction word.
- instr_valid  out  1  output buffer holds an instruction for the decoder.
- instr  out  16  instruction word to decoder.
- instr_pc  out  PC_WIDTH  address the instruction was fetched from.
- instr_ready  in  1  decoder accepts instr this cycle.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  PC_WIDTH  new fetch target.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, state=S_FETCH, drop=0, instr=0, instr_pc=0, instr_valid=0, imem_req=0 during the reset cycle.
- imem_req and instr_valid are Moore outputs of the state. The only exception is instr_valid, which is also gated low combinationally by redirect_valid.
- States and transitions:
  - S_FETCH: imem_req=1, imem_addr=pc. On imem_ready, latch inflight_pc=pc and go to S_WAIT; otherwise stay.
  - S_WAIT: imem_req=0. On imem_rvalid with drop=1: discard the data, clear drop, go to S_FETCH. On imem_rvalid with drop=0: load instr=imem_rdata, instr_pc=inflight_pc, set pc=inflight_pc+PC_STEP, go to S_HOLD.
  - S_HOLD: instr_valid=1, imem_req=0. On instr_ready, go to S_FETCH; otherwise hold instr and instr_pc stable.
- Throughput: at most one instruction per 3 cycles with zero-wait memory (FETCH, WAIT, HOLD). Latency from request acceptance to instr_valid is rvalid delay + 1 cycle.
- PC arithmetic is modulo 2^PC_WIDTH: 0xFFFF + 1 wraps to 0x0000, with no flag.
- Redirect has priority over every other event. In every state pc <= redirect_pc, plus:
  - S_FETCH without imem_ready: stay in S_FETCH; the new address appears next cycle.
  - S_FETCH with imem_ready the same cycle: the old-pc request is accepted; set drop=1 and go to S_WAIT.
  - S_WAIT without imem_rvalid: set drop=1 and stay.
  - S_WAIT with imem_rvalid the same cycle: discard the data, drop stays 0, go to S_FETCH.
  - S_HOLD: clear the buffer (instr_valid=0 from next cycle) and go to S_FETCH. instr_valid is forced 0 in the redirect cycle, so no transfer occurs regardless of instr_ready.
- Subsequent redirects while drop=1 update pc only; drop stays 1. Only one response is ever discarded.
- imem_rvalid outside S_WAIT is a protocol violation; it is ignored with no state change.
- Reset mid-operation (any state): all state returns to reset values immediately. The instruction memory shares rst and drops its outstanding response.
- The decoder treats 0x0000 presented with instr_valid=0 as no instruction; the fetch unit never synthesizes NOPs.

Test Plan:
- Reset, then memory with ready=1 and rvalid 1 cycle later returning 0x4A53, 0x0285, 0xB000 for addr 0, 1, 2, with instr_ready=1 -> instr/instr_pc pairs (0x4A53, 0), (0x0285, 1), (0xB000, 2); instr_valid pulses every 3rd cycle.
- Hold instr_ready=0 for 5 cycles in S_HOLD with instr=0x4A53 -> instr, instr_pc and instr_valid stable; imem_req stays 0; no pc advance.
- Redirect to 0x0040 while in S_WAIT for addr 3, rvalid 2 cycles later with 0xFFFF -> 0xFFFF never appears on instr; next imem_addr=0x0040; the first delivered instr_pc is 0x0040.
- redirect_valid in the same cycle as imem_rvalid, and separately in the same cycle as imem_ready -> response discarded / drop set; next delivered instr_pc equals redirect_pc.
- Redirect to 0xFFFF, fetch one instruction -> instr_pc=0xFFFF, then next imem_addr=0x0000.
- Assert rst for 1 cycle while in S_HOLD with instr_valid=1 -> next cycle instr_valid=0, instr=0, pc=RESET_PC; imem_req=1 on the following cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction fetch stage: PC owner, single-outstanding imem requests, one-entry output buffer.
module fetch_unit #(
    parameter int PC_WIDTH = 16,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [15:0]         imem_rdata,
    output logic                instr_valid,
    output logic [15:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    input  logic                instr_ready,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc
);

    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] STEP   = PC_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic                drop;
    logic                drop_next;
    logic                load;
    logic                latch_inflight;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // drop marks the single in-flight response that a redirect has made stale
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        drop_next      = drop;
        load           = 1'b0;
        latch_inflight = 1'b0;
        case (state)
            S_FETCH: begin
                if (imem_ready) begin
                    latch_inflight = 1'b1;
                    state_next     = S_WAIT;
                    if (redirect_valid) begin
                        drop_next = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    drop_next = 1'b0;
                    if (redirect_valid || drop) begin
                        state_next = S_FETCH;
                    end else begin
                        load       = 1'b1;
                        pc_next    = inflight_pc + STEP;
                        state_next = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || instr_ready) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end
    end

    always_comb begin
        imem_req    = (state == S_FETCH) && !rst;
        instr_valid = (state == S_HOLD) && !redirect_valid;
    end

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RST_PC;
            inflight_pc <= '0;
            drop        <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            pc   <= pc_next;
            drop <= drop_next;
            if (latch_inflight) begin
                inflight_pc <= pc;
            end
            if (load) begin
                instr    <= imem_rdata;
                instr_pc <= inflight_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Cycle-by-cycle vector bench for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.PC_WIDTH(16), .RESET_PC(0), .PC_STEP(1)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [15:0] rdata;
        logic        ir;
        logic        rd;
        logic [15:0] rpc;
        logic        req;
        logic [15:0] addr;
        logic        val;
        logic [15:0] ins;
        logic [15:0] ipc;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rdy, input logic rv, input logic [15:0] rdata,
                     input logic ir, input logic rd, input logic [15:0] rpc,
                     input logic req, input logic [15:0] addr, input logic val,
                     input logic [15:0] ins, input logic [15:0] ipc);
        vec_t e;
        e.rdy = rdy; e.rv = rv; e.rdata = rdata; e.ir = ir; e.rd = rd; e.rpc = rpc;
        e.req = req; e.addr = addr; e.val = val; e.ins = ins; e.ipc = ipc;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 16'h0;
        instr_ready = 0; redirect_valid = 0; redirect_pc = 16'h0;
    endtask

    initial begin
        // 3-cycle stream, 5-cycle stall in HOLD
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000);
        v(0,1,16'h4A53, 0,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000);
        for (int i = 0; i < 5; i++)
            v(0,0,16'h0000, 0,0,16'h0000, 0,16'h0001,1,16'h4A53,16'h0000);
        v(0,0,16'h0000, 1,0,16'h0000, 0,16'h0001,1,16'h4A53,16'h0000);
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0001,0,16'h4A53,16'h0000);
        v(0,1,16'h0285, 0,0,16'h0000, 0,16'h0001,0,16'h4A53,16'h0000);
        v(0,0,16'h0000, 1,0,16'h0000, 0,16'h0002,1,16'h0285,16'h0001);
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0002,0,16'h0285,16'h0001);
        v(0,1,16'hB000, 0,0,16'h0000, 0,16'h0002,0,16'h0285,16'h0001);
        v(0,0,16'h0000, 1,0,16'h0000, 0,16'h0003,1,16'hB000,16'h0002);
        // redirect in WAIT, stale 0xFFFF arrives 2 cycles later
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0003,0,16'hB000,16'h0002);
        v(0,0,16'h0000, 0,1,16'h0040, 0,16'h0003,0,16'hB000,16'h0002);
        v(0,0,16'h0000, 0,0,16'h0000, 0,16'h0040,0,16'hB000,16'h0002);
        v(0,1,16'hFFFF, 0,0,16'h0000, 0,16'h0040,0,16'hB000,16'h0002);
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0040,0,16'hB000,16'h0002);
        v(0,1,16'h1111, 0,0,16'h0000, 0,16'h0040,0,16'hB000,16'h0002);
        v(0,0,16'h0000, 1,0,16'h0000, 0,16'h0041,1,16'h1111,16'h0040);
        // redirect coincident with rvalid
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0041,0,16'h1111,16'h0040);
        v(0,1,16'h2222, 0,1,16'h0100, 0,16'h0041,0,16'h1111,16'h0040);
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0100,0,16'h1111,16'h0040);
        v(0,1,16'h3333, 0,0,16'h0000, 0,16'h0100,0,16'h1111,16'h0040);
        v(0,0,16'h0000, 1,0,16'h0000, 0,16'h0101,1,16'h3333,16'h0100);
        // redirect coincident with imem_ready
        v(1,0,16'h0000, 0,1,16'h0200, 1,16'h0101,0,16'h3333,16'h0100);
        v(0,1,16'h4444, 0,0,16'h0000, 0,16'h0200,0,16'h3333,16'h0100);
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0200,0,16'h3333,16'h0100);
        v(0,1,16'h5555, 0,0,16'h0000, 0,16'h0200,0,16'h3333,16'h0100);
        v(0,0,16'h0000, 1,0,16'h0000, 0,16'h0201,1,16'h5555,16'h0200);
        // redirect in FETCH without ready, to 0xFFFF, then wrap
        v(0,0,16'h0000, 0,1,16'hFFFF, 1,16'h0201,0,16'h5555,16'h0200);
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'hFFFF,0,16'h5555,16'h0200);
        v(0,1,16'h6666, 0,0,16'h0000, 0,16'hFFFF,0,16'h5555,16'h0200);
        v(0,0,16'h0000, 1,0,16'h0000, 0,16'h0000,1,16'h6666,16'hFFFF);
        v(0,0,16'h0000, 0,0,16'h0000, 1,16'h0000,0,16'h6666,16'hFFFF);
        // redirect in HOLD with instr_ready high: no transfer
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0000,0,16'h6666,16'hFFFF);
        v(0,1,16'h7777, 0,0,16'h0000, 0,16'h0000,0,16'h6666,16'hFFFF);
        v(0,0,16'h0000, 1,1,16'h0300, 0,16'h0001,0,16'h7777,16'h0000);
        v(0,0,16'h0000, 0,0,16'h0000, 1,16'h0300,0,16'h7777,16'h0000);
        // back-to-back redirects while a response is pending: one discard only
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0300,0,16'h7777,16'h0000);
        v(0,0,16'h0000, 0,1,16'h0400, 0,16'h0300,0,16'h7777,16'h0000);
        v(0,0,16'h0000, 0,1,16'h0500, 0,16'h0400,0,16'h7777,16'h0000);
        v(0,1,16'hEEEE, 0,0,16'h0000, 0,16'h0500,0,16'h7777,16'h0000);
        v(1,0,16'h0000, 0,0,16'h0000, 1,16'h0500,0,16'h7777,16'h0000);
        v(0,1,16'h8888, 0,0,16'h0000, 0,16'h0500,0,16'h7777,16'h0000);
        v(0,0,16'h0000, 0,0,16'h0000, 0,16'h0501,1,16'h8888,16'h0500);
        // stray rvalid in HOLD is ignored
        v(0,1,16'h9999, 0,0,16'h0000, 0,16'h0501,1,16'h8888,16'h0500);
        v(0,0,16'h0000, 0,0,16'h0000, 0,16'h0501,1,16'h8888,16'h0500);

        rst = 1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_req", 16'(imem_req), 16'h0);
        chk("reset_valid", 16'(instr_valid), 16'h0);
        chk("reset_instr", instr, 16'h0000);
        chk("reset_instr_pc", instr_pc, 16'h0000);
        chk("reset_addr", imem_addr, 16'h0000);
        @(negedge clk);
        rst = 0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            imem_ready     = vecs[i].rdy;
            imem_rvalid    = vecs[i].rv;
            imem_rdata     = vecs[i].rdata;
            instr_ready    = vecs[i].ir;
            redirect_valid = vecs[i].rd;
            redirect_pc    = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d_req", i), 16'(imem_req), 16'(vecs[i].req));
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("v%0d_valid", i), 16'(instr_valid), 16'(vecs[i].val));
            chk($sformatf("v%0d_instr", i), instr, vecs[i].ins);
            chk($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].ipc);
        end

        // reset while holding a valid instruction
        @(negedge clk);
        idle_inputs();
        rst = 1;
        #1;
        chk("midrst_req", 16'(imem_req), 16'h0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("postrst_valid", 16'(instr_valid), 16'h0);
        chk("postrst_instr", instr, 16'h0000);
        chk("postrst_instr_pc", instr_pc, 16'h0000);
        chk("postrst_addr", imem_addr, 16'h0000);
        chk("postrst_req", 16'(imem_req), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
